// File: rtl/axi4_mem_target.sv
// AXI4 subordinate backed by a byte-writable register-array memory, with independent read and write FSMs.
// Optional LFSR-driven handshake throttling is enabled by defining AXI4_MEM_TARGET_BACKPRESSURE_EN.
module axi4_mem_target #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 64,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MEM_DEPTH_LOG2     = 10
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]    AWADDR,
  input  logic [AXI4_ID_WIDTH-1:0]         AWID,
  input  logic [7:0]                       AWLEN,
  input  logic [2:0]                       AWSIZE,
  input  logic [1:0]                       AWBURST,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [AXI4_DATA_WIDTH-1:0]       WDATA,
  input  logic [AXI4_DATA_WIDTH/8-1:0]     WSTRB,
  input  logic                             WLAST,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [AXI4_ID_WIDTH-1:0]         BID,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]    ARADDR,
  input  logic [AXI4_ID_WIDTH-1:0]         ARID,
  input  logic [7:0]                       ARLEN,
  input  logic [2:0]                       ARSIZE,
  input  logic [1:0]                       ARBURST,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [AXI4_ID_WIDTH-1:0]         RID,
  output logic [AXI4_DATA_WIDTH-1:0]       RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RLAST,
  output logic                             RVALID,
  input  logic                             RREADY
);

  localparam int AW    = AXI4_ADDRESS_WIDTH;
  localparam int DW    = AXI4_DATA_WIDTH;
  localparam int IW    = AXI4_ID_WIDTH;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [AW-1:0] a);
    return a[LSB +: MEM_DEPTH_LOG2];
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (AW'(1) << size);
  endfunction

  // WRAP and the reserved encoding are unsupported, as is any beat wider than the bus.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (int'(size) > LSB);
  endfunction

  logic [DW-1:0] mem_q [DEPTH];

  logic bp_w;
  logic bp_r;
`ifdef AXI4_MEM_TARGET_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
  // WREADY is registered, so look one step ahead to gate it in the cycle the bit applies to.
  assign bp_w = lfsr_d[0];
  assign bp_r = lfsr_q[1];
`else
  assign bp_w = 1'b0;
  assign bp_r = 1'b0;
`endif

  w_state_t      w_state_q, w_state_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [IW-1:0] bid_q, bid_d, wid_q, wid_d;
  logic [1:0]    bresp_q, bresp_d, wburst_q, wburst_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]    wsize_q, wsize_d;
  logic          werr_q, werr_d;
  logic          w_last, w_mism, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    w_last    = (wcnt_q == wlen_q);
    w_mism    = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (AWVALID && awready_q) begin
        waddr_d   = AWADDR;
        wid_d     = AWID;
        wlen_d    = AWLEN;
        wsize_d   = AWSIZE;
        wburst_d  = AWBURST;
        wcnt_d    = 8'd0;
        werr_d    = burst_err(AWSIZE, AWBURST);
        w_state_d = W_DATA;
      end
      W_DATA: if (WVALID && wready_q) begin
        w_mism  = (WLAST != w_last);
        mem_we  = !(werr_q || w_mism);
        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
        wcnt_d  = wcnt_q + 8'd1;
        werr_d  = werr_q || w_mism;
        if (w_last) begin
          w_state_d = W_RESP;
          bid_d     = wid_q;
          bresp_d   = (werr_q || w_mism) ? 2'b10 : 2'b00;
        end
      end
      W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA) && !bp_w;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clock) begin
    wid_q    <= wid_d;
    waddr_q  <= waddr_d;
    wlen_q   <= wlen_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
    wcnt_q   <= wcnt_d;
    werr_q   <= werr_d;
  end

  logic [MEM_DEPTH_LOG2-1:0] w_idx;
  assign w_idx = word_idx(waddr_q);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (WSTRB[b]) mem_q[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  r_state_t      r_state_q, r_state_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [IW-1:0] rid_q, rid_d, rid_lat_q, rid_lat_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d, rburst_q, rburst_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]    rsize_q, rsize_d;
  logic          rerr_q, rerr_d;
  logic          r_load;

  // rcnt counts beats already loaded onto R; raddr always points at the next beat to load.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_lat_d = rid_lat_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: if (ARVALID && arready_q) begin
        raddr_d   = ARADDR;
        rid_lat_d = ARID;
        rlen_d    = ARLEN;
        rsize_d   = ARSIZE;
        rburst_d  = ARBURST;
        rcnt_d    = 8'd0;
        rerr_d    = burst_err(ARSIZE, ARBURST);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else if (!bp_r) begin
            r_load = 1'b1;
          end else begin
            rvalid_d = 1'b0;
          end
        end else if (!rvalid_q && !bp_r) begin
          r_load = 1'b1;
        end
        if (r_load) begin
          rvalid_d = 1'b1;
          rid_d    = rid_lat_q;
          rdata_d  = rerr_q ? '0 : mem_q[word_idx(raddr_q)];
          rresp_d  = rerr_q ? 2'b10 : 2'b00;
          rlast_d  = (rcnt_q == rlen_q);
          raddr_d  = next_addr(raddr_q, rsize_q, rburst_q);
          rcnt_d   = rcnt_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge clock) begin
    rid_lat_q <= rid_lat_d;
    raddr_q   <= raddr_d;
    rlen_q    <= rlen_d;
    rsize_q   <= rsize_d;
    rburst_q  <= rburst_d;
    rcnt_q    <= rcnt_d;
    rerr_q    <= rerr_d;
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_mem_target.sv
// Directed bench for axi4_mem_target: bursts, strobes, stalls, error bursts and mid-burst reset.
module tb_axi4_mem_target;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;

  int errors = 0;
  int checks = 0;

  axi4_mem_target dut (
    .clock(clock), .reset(reset),
    .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_sig(input string tag, ref logic s);
    int n = 0;
    while (s !== 1'b1 && n < 200) begin tick(); n++; end
    chk(tag, {63'd0, s}, 64'd1);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    AWADDR = a; AWID = id; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
    wait_sig("aw_wait", AWREADY);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] strb, input logic last);
    WDATA = d; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    wait_sig("w_wait", WREADY);
    tick();
    WVALID = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp, output logic [3:0] id);
    BREADY = 1'b1;
    wait_sig("b_wait", BVALID);
    resp = BRESP; id = BID;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    ARADDR = a; ARID = id; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1'b1;
    wait_sig("ar_wait", ARREADY);
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic r_take(output logic [63:0] d, output logic [1:0] resp, output logic last,
                        output logic [3:0] id);
    RREADY = 1'b1;
    wait_sig("r_wait", RVALID);
    d = RDATA; resp = RRESP; last = RLAST; id = RID;
    tick();
    RREADY = 1'b0;
  endtask

  logic [63:0] d;
  logic [1:0]  resp;
  logic [3:0]  id;
  logic        last;

  initial begin
    reset = 1'b1;
    AWADDR = '0; AWID = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARID = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) tick();

    chk("rst_awready", {63'd0, AWREADY}, 64'd0);
    chk("rst_wready",  {63'd0, WREADY},  64'd0);
    chk("rst_bvalid",  {63'd0, BVALID},  64'd0);
    chk("rst_arready", {63'd0, ARREADY}, 64'd0);
    chk("rst_rvalid",  {63'd0, RVALID},  64'd0);
    chk("rst_rlast",   {63'd0, RLAST},   64'd0);
    chk("rst_rdata",   RDATA, 64'd0);
    chk("rst_bresp",   {62'd0, BRESP}, 64'd0);
    reset = 1'b0;
    tick();

    // 4-beat INCR write and read-back
    aw_send(32'h100, 4'h5, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(64'h11 * (i + 1), 8'hFF, i == 3);
    b_take(resp, id);
    chk("wr1_bresp", {62'd0, resp}, 64'd0);
    chk("wr1_bid",   {60'd0, id},   64'd5);
    ar_send(32'h100, 4'h6, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_take(d, resp, last, id);
      chk($sformatf("rd1_data%0d", i), d, 64'h11 * (i + 1));
      chk($sformatf("rd1_last%0d", i), {63'd0, last}, (i == 3) ? 64'd1 : 64'd0);
      chk($sformatf("rd1_resp%0d", i), {62'd0, resp}, 64'd0);
    end
    chk("rd1_rid", {60'd0, id}, 64'd6);

    // Byte strobes
    aw_send(32'h200, 4'h1, 8'd0, 3'd3, 2'b01);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_take(resp, id);
    aw_send(32'h200, 4'h1, 8'd0, 3'd3, 2'b01);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_take(resp, id);
    ar_send(32'h200, 4'h2, 8'd0, 3'd3, 2'b01);
    r_take(d, resp, last, id);
    chk("strb_data", d, 64'hFFFF_FFFF_0000_0000);
    chk("strb_last", {63'd0, last}, 64'd1);

    // 8-beat source region, then read it with RREADY toggling
    aw_send(32'h300, 4'h3, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 8; i++) w_beat(64'h1000 + i, 8'hFF, i == 7);
    b_take(resp, id);
    chk("wr8_bresp", {62'd0, resp}, 64'd0);
    ar_send(32'h300, 4'h4, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 8; i++) begin
      RREADY = 1'b0;
      wait_sig("stall_rvalid", RVALID);
      chk($sformatf("stall_data%0d", i), RDATA, 64'h1000 + i);
      chk($sformatf("stall_arready%0d", i), {63'd0, ARREADY}, 64'd0);
      tick();
      chk($sformatf("stall_hold%0d", i), RDATA, 64'h1000 + i);
      chk($sformatf("stall_last%0d", i), {63'd0, RLAST}, (i == 7) ? 64'd1 : 64'd0);
      RREADY = 1'b1;
      tick();
    end
    RREADY = 1'b0;
    chk("stall_end_rvalid",  {63'd0, RVALID},  64'd0);
    chk("stall_end_arready", {63'd0, ARREADY}, 64'd1);

    // WRAP write is an error burst and leaves memory untouched
    aw_send(32'h100, 4'h7, 8'd1, 3'd3, 2'b10);
    w_beat(64'hDEAD, 8'hFF, 1'b0);
    w_beat(64'hBEEF, 8'hFF, 1'b1);
    b_take(resp, id);
    chk("wrap_bresp", {62'd0, resp}, 64'd2);
    chk("wrap_bid",   {60'd0, id},   64'd7);
    ar_send(32'h100, 4'h0, 8'd0, 3'd3, 2'b01);
    r_take(d, resp, last, id);
    chk("wrap_mem", d, 64'h11);
    ar_send(32'h100, 4'h0, 8'd0, 3'd4, 2'b01);
    r_take(d, resp, last, id);
    chk("size_rresp", {62'd0, resp}, 64'd2);
    chk("size_rdata", d, 64'd0);

    // FIXED burst overwrites one word
    aw_send(32'h500, 4'h1, 8'd1, 3'd3, 2'b00);
    w_beat(64'hAAAA, 8'hFF, 1'b0);
    w_beat(64'hBBBB, 8'hFF, 1'b1);
    b_take(resp, id);
    ar_send(32'h500, 4'h1, 8'd0, 3'd3, 2'b01);
    r_take(d, resp, last, id);
    chk("fixed_data", d, 64'hBBBB);

    // Early WLAST still takes AWLEN+1 beats; B held under back-pressure
    aw_send(32'h400, 4'h9, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(64'h5 + i, 8'hFF, i == 1 || i == 3);
    BREADY = 1'b0;
    wait_sig("wlast_bvalid", BVALID);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bhold_bvalid%0d", i),  {63'd0, BVALID},  64'd1);
      chk($sformatf("bhold_awready%0d", i), {63'd0, AWREADY}, 64'd0);
    end
    b_take(resp, id);
    chk("wlast_bresp", {62'd0, resp}, 64'd2);
    chk("wlast_bid",   {60'd0, id},   64'd9);
    chk("b_awready",   {63'd0, AWREADY}, 64'd1);

    // Reset during beat 2 of an 8-beat read
    ar_send(32'h300, 4'h2, 8'd7, 3'd3, 2'b01);
    r_take(d, resp, last, id);
    chk("rst_rd_b0", d, 64'h1000);
    r_take(d, resp, last, id);
    chk("rst_rd_b1", d, 64'h1001);
    wait_sig("rst_rd_b2v", RVALID);
    chk("rst_rd_b2", RDATA, 64'h1002);
    reset = 1'b1;
    tick();
    chk("rst_mid_rvalid", {63'd0, RVALID}, 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_mid_arready", {63'd0, ARREADY}, 64'd1);
    ar_send(32'h300, 4'hA, 8'd0, 3'd3, 2'b01);
    r_take(d, resp, last, id);
    chk("post_rst_data", d, 64'h1000);
    chk("post_rst_last", {63'd0, last}, 64'd1);
    chk("post_rst_rid",  {60'd0, id},   64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
